// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the two-requester AHB command arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } arb_req_t;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection for two requesters.
// AHB_ARB_RR_EN: pointer-based round-robin; otherwise fixed priority to m0.
module arb_grant_sel
  import ahb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef AHB_ARB_RR_EN
  input  logic               ptr,
`endif
  output logic               gnt_vld,
  output logic               gnt_id
);

  assign gnt_vld = |req;

`ifdef AHB_ARB_RR_EN
  // On contention the pointer decides; a lone requester always wins.
  assign gnt_id = (req[0] & req[1]) ? ptr : req[1];
`else
  assign gnt_id = ~req[0] & req[1];
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// Two-requester arbiter in front of ahb_master with per-access timeout.
// AHB_ARB_RR_EN selects round-robin arbitration (default: m0 fixed priority).
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wr,
  input  logic [2:0]  m0_size,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wr,
  input  logic [2:0]  m1_size,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] ram_addr_i,
  output logic [2:0]  ram_size_i,
  output logic        ram_rd_en,
  output logic        ram_wd_en,
  output logic [31:0] ram_wd_data,
  input  logic [31:0] ram_rd_data,
  input  logic        ram_ready,
  output logic        busy_o
);

  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

  arb_state_e                     state, state_nxt;
  arb_req_t [NUM_REQ-1:0]         req_bus;
  arb_req_t                       win;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             done_q, err_q;
  logic [NUM_REQ-1:0][31:0]       rdata_q;
  logic [CW-1:0]                  tmo_cnt;
  logic                           owner, gnt_vld, gnt_id;
  logic                           grant, fin_ok, fin_to;

  assign req        = {m1_req, m0_req};
  assign req_bus[0] = '{addr: m0_addr, wr: m0_wr, size: m0_size, wdata: m0_wdata};
  assign req_bus[1] = '{addr: m1_addr, wr: m1_wr, size: m1_size, wdata: m1_wdata};
  assign win        = req_bus[gnt_id];

`ifdef AHB_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n)                rr_ptr <= 1'b0;
    else if (state == ST_RELEASE) rr_ptr <= ~owner;

  arb_grant_sel u_sel (.req(req), .ptr(rr_ptr), .gnt_vld(gnt_vld), .gnt_id(gnt_id));
`else
  arb_grant_sel u_sel (.req(req), .gnt_vld(gnt_vld), .gnt_id(gnt_id));
`endif

  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) state <= ST_IDLE;
    else           state <= state_nxt;

  // ram_ready wins over the timeout when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    unique case (state)
      ST_IDLE: if (gnt_vld) begin
        grant     = 1'b1;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: if (ram_ready) begin
        fin_ok    = 1'b1;
        state_nxt = ST_RELEASE;
      end else if (tmo_cnt == TMO_LAST) begin
        fin_to    = 1'b1;
        state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      owner       <= 1'b0;
      tmo_cnt     <= '0;
      ram_addr_i  <= '0;
      ram_size_i  <= '0;
      ram_rd_en   <= 1'b0;
      ram_wd_en   <= 1'b0;
      ram_wd_data <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      if (grant) begin
        owner       <= gnt_id;
        ram_addr_i  <= win.addr;
        ram_size_i  <= win.size;
        ram_wd_data <= win.wdata;
        ram_rd_en   <= ~win.wr;
        ram_wd_en   <= win.wr;
      end
      if (state == ST_BUSY)    tmo_cnt <= tmo_cnt + CW'(1);
      if (state == ST_RELEASE) tmo_cnt <= '0;
      if (fin_ok || fin_to) begin
        ram_rd_en <= 1'b0;
        ram_wd_en <= 1'b0;
      end
      if (fin_ok) begin
        done_q[owner] <= 1'b1;
        if (!ram_wd_en) rdata_q[owner] <= ram_rd_data;
      end
      if (fin_to) err_q[owner] <= 1'b1;
    end
  end

  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign busy_o   = (state != ST_IDLE);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: cycle model plus directed literal checks.
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  localparam int TMO = 4;

  logic        hclk = 1'b0, hreset_n = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [2:0]  m0_size = 0, m1_size = 0;
  logic [31:0] m0_rdata, m1_rdata, ram_addr_i, ram_wd_data;
  logic        m0_done, m0_err, m1_done, m1_err, ram_rd_en, ram_wd_en, busy_o;
  logic [2:0]  ram_size_i;
  logic [31:0] ram_rd_data = 0;
  logic        ram_ready = 0;

  int errors = 0, checks = 0, cyc = 0;
  int lat = 1, rcnt = 0;
  logic [31:0] rdval = 0;
  bit chk_en = 0;
  int gq[$];

  ahb_arbiter #(.TIMEOUT(TMO)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .ram_addr_i(ram_addr_i), .ram_size_i(ram_size_i), .ram_rd_en(ram_rd_en), .ram_wd_en(ram_wd_en),
    .ram_wd_data(ram_wd_data), .ram_rd_data(ram_rd_data), .ram_ready(ram_ready), .busy_o(busy_o)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  // Memory responder: ready on the lat-th cycle an enable is seen; lat=0 never answers.
  always @(negedge hclk) begin
    if (ram_rd_en || ram_wd_en) rcnt = rcnt + 1;
    else                        rcnt = 0;
    ram_ready   = (lat != 0) && (rcnt == lat);
    ram_rd_data = rdval;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 access open, 2 turnaround; age counts cycles since grant.
  int          ph = 0, mw = 0, age = 0, mptr = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [2:0]  e_size = 0;
  logic        e_rd = 0, e_wd = 0;
  logic [1:0]  e_done = 0, e_err = 0;
  logic [31:0] e_rdata [2] = '{0, 0};

  function automatic int pick(input bit r0, input bit r1);
`ifdef AHB_ARB_RR_EN
    if (r0 && r1) return mptr;
`endif
    return r0 ? 0 : (r1 ? 1 : 0);
  endfunction

  always @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      ph = 0; mw = 0; age = 0; mptr = 0;
      e_addr = 0; e_wdata = 0; e_size = 0; e_rd = 0; e_wd = 0;
      e_done = 0; e_err = 0; e_rdata[0] = 0; e_rdata[1] = 0;
    end else begin
      e_done = 0;
      e_err  = 0;
      if (ph == 0) begin
        if (m0_req || m1_req) begin
          mw      = pick(m0_req, m1_req);
          e_addr  = mw ? m1_addr  : m0_addr;
          e_size  = mw ? m1_size  : m0_size;
          e_wdata = mw ? m1_wdata : m0_wdata;
          e_wd    = mw ? m1_wr    : m0_wr;
          e_rd    = !e_wd;
          age = 0;
          ph  = 1;
        end
      end else if (ph == 1) begin
        age++;
        if (ram_ready) begin
          if (e_rd) e_rdata[mw] = ram_rd_data;
          e_done[mw] = 1'b1;
          e_rd = 0; e_wd = 0; ph = 2;
        end else if (age == TMO + 1) begin
          e_err[mw] = 1'b1;
          e_rd = 0; e_wd = 0; ph = 2;
        end
      end else begin
        ph   = 0;
        mptr = 1 - mw;
      end
    end
  end

  logic en_prev = 0;
  always @(posedge hclk) begin
    #1;
    if (hreset_n && chk_en) begin
      chk("cmd", {ram_addr_i, ram_size_i, ram_rd_en, ram_wd_en, ram_wd_data},
                 {e_addr, e_size, e_rd, e_wd, e_wdata});
      chk("status", {m0_done, m1_done, m0_err, m1_err, busy_o},
                    {e_done[0], e_done[1], e_err[0], e_err[1], ph != 0});
      chk("rdata", {m0_rdata, m1_rdata}, {e_rdata[0], e_rdata[1]});
    end
    if ((ram_rd_en || ram_wd_en) && !en_prev) gq.push_back(ram_addr_i[13] ? 1 : 0);
    en_prev = ram_rd_en || ram_wd_en;
  end

  task automatic wait_en();
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge hclk);
      if (ram_rd_en || ram_wd_en) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_grant: no enable within budget"); end
  endtask

  task automatic wait_done(input int id);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge hclk);
      if (id == 0 ? (m0_done || m0_err) : (m1_done || m1_err)) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_m%0d: no done/err within budget", id); end
  endtask

  task automatic wait_any();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge hclk);
      if (m0_done || m1_done) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_any: no done within budget"); end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cmd"}, {ram_addr_i, ram_size_i, ram_rd_en, ram_wd_en, ram_wd_data, busy_o}, '0);
    chk({nm, "_rsp"}, {m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err}, '0);
  endtask

  initial begin
    int base, t0, t1;
    int exp_g [4];
`ifdef AHB_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    #1 hreset_n = 1'b0;
    repeat (2) @(negedge hclk);
    chk_all_zero("reset");
    hreset_n = 1'b1;
    chk_en   = 1;

    // single read
    lat = 2; rdval = 32'hDEADBEEF;
    m0_addr = 32'h100; m0_size = SIZE_WORD; m0_wr = 0; m0_req = 1;
    wait_done(0);
    m0_req = 0;
    chk("rd_kind", {m0_done, m0_err}, 2'b10);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    @(negedge hclk);
    chk("rd_pulse", m0_done, 1'b0);

    // single write
    lat = 3;
    m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_size = SIZE_HALF; m1_wr = 1; m1_req = 1;
    wait_en();
    chk("wr_cmd", {ram_wd_en, ram_rd_en, ram_wd_data, ram_size_i, ram_addr_i},
                  {1'b1, 1'b0, 32'h12345678, 3'b001, 32'h200});
    wait_done(1);
    m1_req = 0;
    chk("wr_kind", {m1_done, m1_err}, 2'b10);

    // contention
    lat = 1; rdval = 32'h0BADF00D;
    m0_addr = 32'h1000; m0_wr = 0; m1_addr = 32'h2000; m1_wr = 0;
    base = gq.size();
    m0_req = 1; m1_req = 1;
    repeat (4) wait_any();
    m0_req = 0; m1_req = 0;
    chk("cont_cnt", (gq.size() >= base + 4), 1'b1);
    for (int i = 0; i < 4; i++)
      if (gq.size() > base + i) chk($sformatf("cont_gnt%0d", i), gq[base+i], exp_g[i]);

    // timeout
    repeat (2) @(negedge hclk);
    lat = 0;
    m0_addr = 32'h300; m0_wr = 0; m0_req = 1;
    wait_en();
    t0 = cyc;
    wait_done(0);
    t1 = cyc;
    m0_req = 0;
    chk("tmo_kind", {m0_err, m0_done}, 2'b10);
    chk("tmo_lat", t1 - t0, 5);
    chk("tmo_en", {ram_rd_en, ram_wd_en}, 2'b00);

    // ready on the timeout cycle
    lat = TMO + 1; rdval = 32'hCAFE0001;
    m1_addr = 32'h400; m1_wr = 0; m1_req = 1;
    wait_done(1);
    m1_req = 0;
    chk("bnd_kind", {m1_done, m1_err}, 2'b10);
    chk("bnd_data", m1_rdata, 32'hCAFE0001);

    // reset mid-access
    repeat (2) @(negedge hclk);
    lat = 0;
    m0_addr = 32'h500; m0_wr = 0; m0_req = 1;
    wait_en();
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1 chk_all_zero("midrst");
    m0_req = 0;
    @(negedge hclk);
    hreset_n = 1'b1;
    lat = 1; rdval = 32'h55AA55AA;
    m1_addr = 32'h600; m1_wr = 0; m1_req = 1;
    wait_done(1);
    m1_req = 0;
    chk("post_rst", {m1_done, m1_err, m1_rdata}, {2'b10, 32'h55AA55AA});

    repeat (4) @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-requester arbiter sharing the core's single `ahb_master` command port. Requester 0 is the execute-stage load/store path. Requester 1 is a secondary agent, such as a debug or DMA port. The block sits between the requesters and `ahb_master`, serialises their accesses, returns read data and completion to the winner, and aborts any access that `ram_ready` never completes.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait for `ram_ready`; legal range 1–65535.
- `hclk` in 1: clock.
- `hreset_n` in 1: asynchronous, active-low reset.
- `m0_req` / `m1_req` in 1: access request; held high until `mX_done` or `mX_err`.
- `m0_addr` / `m1_addr` in 32: byte address.
- `m0_wr` / `m1_wr` in 1: 1 = write, 0 = read.
- `m0_size` / `m1_size` in 3: 000 byte, 001 half, 010 word.
- `m0_wdata` / `m1_wdata` in 32: write data.
- `m0_rdata` / `m1_rdata` out 32: registered read data; valid with `mX_done`.
- `m0_done` / `m1_done` out 1: one-cycle completion pulse.
- `m0_err` / `m1_err` out 1: one-cycle timeout pulse.
- `ram_addr_i` out 32, `ram_size_i` out 3, `ram_rd_en` out 1, `ram_wd_en` out 1, `ram_wd_data` out 32: command to `ahb_master`.
- `ram_rd_data` in 32, `ram_ready` in 1: response from `ahb_master`.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, BUSY, RELEASE.
- **Reset values:** all outputs 0; state IDLE; round-robin pointer favours m0; timeout counter 0.
- **IDLE:**
  - If any `mX_req` is high, select a winner with the arbitration rule below.
  - Register the winner's address, size, wr and wdata into the `ram_*` outputs.
  - Assert `ram_rd_en` (when wr=0) or `ram_wd_en` (when wr=1).
  - Go to BUSY.
- **BUSY:**
  - Command outputs are held constant.
  - The timeout counter increments each cycle.
  - On `ram_ready`=1: capture `ram_rd_data` into the winner's `mX_rdata` (reads only; writes leave it unchanged), pulse `mX_done`, drop both enables, go to RELEASE.
  - If the counter reaches TIMEOUT without `ram_ready`: pulse `mX_err`, drop both enables, go to RELEASE.
  - `ram_ready` on the same cycle the counter reaches TIMEOUT counts as success.
- **RELEASE:**
  - Exactly one idle cycle, giving the winner time to deassert req.
  - Clear the counter, update the round-robin pointer, go to IDLE.
  - Requests are not sampled in this state.
- **Request rules:**
  - A requester dropping req during BUSY does not cancel the access; the done/err pulse is still issued.
  - The loser's req stays pending and is served in the next IDLE.
- **Unsupported size:** size values 011–111 are forwarded unchanged; no checking.
- **Reset mid-access:** all outputs return to 0 immediately; no done/err pulse is issued; the in-flight bus access is abandoned (`ahb_master` is reset by the same signal).

## Timing
- **Request to command:** request sampled in IDLE at edge N; `ram_*` command valid after edge N (1 cycle latency).
- **Completion:** `ram_ready` high in the cycle before edge M; `mX_done` and `mX_rdata` valid after edge M.
- **Back-to-back:** minimum 3 cycles per access (IDLE, BUSY, RELEASE). The next grant's command appears 2 cycles after done.
- **Timeout:** `mX_err` asserts after edge TIMEOUT+1 counted from grant.
- **Simultaneous requests in IDLE:** resolved by the arbitration rule; one grant per IDLE cycle.

## Configuration
- `AHB_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer toggles to the non-winner after each RELEASE.
  - On simultaneous requests, the requester the pointer favours wins.
- `AHB_ARB_RR_EN` not defined: fixed priority; m0 always wins simultaneous requests, and the pointer register is removed.

## Structure
- **Package `ahb_arb_pkg`:** state encoding (IDLE=0, BUSY=1, RELEASE=2), size constants (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`), and the counter width derived from TIMEOUT.
- **Sub-module `arb_grant_sel`:** combinational winner selection from req[1:0] and the pointer. It contains both the round-robin and fixed-priority variants under the macro.
- **Top level:** the FSM, timeout counter and output registers stay in `ahb_arbiter`.

## Test plan
- **Single read:**
  - Stimulus: m0 read, `m0_addr`=0x100, size 010; `ram_ready` asserted 2 cycles after `ram_rd_en`, with `ram_rd_data`=0xDEADBEEF.
  - Required: `m0_done` pulses once and `m0_rdata`=0xDEADBEEF.
- **Single write:**
  - Stimulus: m1 write, `m1_addr`=0x200, `m1_wdata`=0x12345678, size 001.
  - Required: `ram_wd_en`=1, `ram_wd_data`=0x12345678, `ram_size_i`=001 held until `ram_ready`; then `m1_done` pulses.
- **Contention:**
  - Stimulus: both requesters hold req continuously; `ram_ready` returned after 1 cycle each access.
  - Required with RR: grants alternate m0, m1, m0, m1.
  - Required without RR: m0 is granted every time.
- **Timeout:**
  - Stimulus: TIMEOUT=4; `ram_ready` held at 0.
  - Required: `m0_err` pulses 5 cycles after grant; enables drop; `m0_done` never asserts.
- **Reset mid-access:**
  - Stimulus: `hreset_n` driven low during BUSY.
  - Required: all outputs are 0 within the same cycle; after release, a new m1 request is served normally.
- **Ready at timeout boundary:**
  - Stimulus: `ram_ready`=1 on the cycle the counter reaches TIMEOUT.
  - Required: `mX_done` pulses and `mX_err` stays 0.
